// File: rtl/control_pkg.sv
// Shared constants and types for the Mini-SRC hardwired control unit.
// Holds the 5-bit opcode map, ALU operation codes, T-state encodings and
// the opcode class enumeration used by the classifier and the sequencer.
package control_pkg;

  localparam int unsigned OpcW = 5;

  // Opcodes (IR[31:27])
  localparam logic [OpcW-1:0] OpLd   = 5'b00000;
  localparam logic [OpcW-1:0] OpLdi  = 5'b00001;
  localparam logic [OpcW-1:0] OpSt   = 5'b00010;
  localparam logic [OpcW-1:0] OpAdd  = 5'b00011;
  localparam logic [OpcW-1:0] OpSub  = 5'b00100;
  localparam logic [OpcW-1:0] OpAnd  = 5'b00101;
  localparam logic [OpcW-1:0] OpOr   = 5'b00110;
  localparam logic [OpcW-1:0] OpShr  = 5'b00111;
  localparam logic [OpcW-1:0] OpShl  = 5'b01000;
  localparam logic [OpcW-1:0] OpAddi = 5'b01001;
  localparam logic [OpcW-1:0] OpAndi = 5'b01010;
  localparam logic [OpcW-1:0] OpOri  = 5'b01011;

  // ALU operation codes; cast to the port width at the point of use
  localparam int unsigned AluAdd = 0;
  localparam int unsigned AluSub = 1;
  localparam int unsigned AluAnd = 2;
  localparam int unsigned AluOr  = 3;
  localparam int unsigned AluShr = 4;
  localparam int unsigned AluShl = 5;

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4,
    T5 = 3'd5,
    T6 = 3'd6,
    T7 = 3'd7
  } tstate_e;

  typedef enum logic [2:0] {
    ClsRalu,
    ClsIalu,
    ClsLd,
    ClsLdi,
    ClsSt,
    ClsIllegal
  } op_class_e;

endpackage

// File: rtl/control_opcode_class.sv
// Combinational opcode classifier.
// Ports:
//   opcode   - IR[31:27]
//   op_class - instruction class (R-ALU, I-ALU, ld, ldi, st, illegal)
//   alu_op   - ALU operation for ALU classes, ADD for everything else
module control_opcode_class
  import control_pkg::*;
#(
  parameter int unsigned OPC_W    = 5,
  parameter int unsigned ALU_OP_W = 4
) (
  input  logic [OPC_W-1:0]    opcode,
  output op_class_e           op_class,
  output logic [ALU_OP_W-1:0] alu_op
);

  always_comb begin
    op_class = ClsIllegal;
    alu_op   = ALU_OP_W'(AluAdd);
    case (opcode)
      OPC_W'(OpLd):   op_class = ClsLd;
      OPC_W'(OpLdi):  op_class = ClsLdi;
      OPC_W'(OpSt):   op_class = ClsSt;
      OPC_W'(OpAdd):  begin op_class = ClsRalu; alu_op = ALU_OP_W'(AluAdd); end
      OPC_W'(OpSub):  begin op_class = ClsRalu; alu_op = ALU_OP_W'(AluSub); end
      OPC_W'(OpAnd):  begin op_class = ClsRalu; alu_op = ALU_OP_W'(AluAnd); end
      OPC_W'(OpOr):   begin op_class = ClsRalu; alu_op = ALU_OP_W'(AluOr);  end
      OPC_W'(OpShr):  begin op_class = ClsRalu; alu_op = ALU_OP_W'(AluShr); end
      OPC_W'(OpShl):  begin op_class = ClsRalu; alu_op = ALU_OP_W'(AluShl); end
      OPC_W'(OpAddi): begin op_class = ClsIalu; alu_op = ALU_OP_W'(AluAdd); end
      OPC_W'(OpAndi): begin op_class = ClsIalu; alu_op = ALU_OP_W'(AluAnd); end
      OPC_W'(OpOri):  begin op_class = ClsIalu; alu_op = ALU_OP_W'(AluOr);  end
      default:        op_class = ClsIllegal;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Mini-SRC hardwired control unit: one T-state per clock, T0..T7.
// Ports:
//   in_clk, in_reset_n        - clock, async active-low reset
//   in_run                    - allow a new fetch to start from T0
//   in_ir                     - instruction register (valid from T3)
//   in_mem_ack                - memory completion
//   out_* strobes             - datapath, memory and register-select controls
//   out_alu_op                - ALU operation (meaningful in T4)
//   out_illegal               - one-cycle pulse on an undecodable opcode
//   out_state                 - current T-state
module control_sequencer
  import control_pkg::*;
#(
  parameter int unsigned OPC_W    = 5,
  parameter int unsigned ALU_OP_W = 4
) (
  input  logic                in_clk,
  input  logic                in_reset_n,
  input  logic                in_run,
  input  logic [31:0]         in_ir,
  input  logic                in_mem_ack,
  output logic                out_pcout,
  output logic                out_pcin,
  output logic                out_incpc,
  output logic                out_marin,
  output logic                out_mdrin,
  output logic                out_mdrout,
  output logic                out_irin,
  output logic                out_mem_read,
  output logic                out_mem_write,
  output logic                out_mdr_from_mem,
  output logic                out_gra,
  output logic                out_grb,
  output logic                out_grc,
  output logic                out_rout,
  output logic                out_rin,
  output logic                out_baout,
  output logic                out_yin,
  output logic                out_zin,
  output logic                out_zlowout,
  output logic                out_cout,
  output logic [ALU_OP_W-1:0] out_alu_op,
  output logic                out_illegal,
  output logic [2:0]          out_state
);

  tstate_e               state_q, state_d;
  logic                  t1_wait_q;  // stalled in T1 past its first cycle
  op_class_e             op_class;
  logic [ALU_OP_W-1:0]   cls_alu_op;
  logic                  is_alu;
  logic                  unused_ir;

  assign unused_ir = ^in_ir[31-OPC_W:0];

  control_opcode_class #(
    .OPC_W    (OPC_W),
    .ALU_OP_W (ALU_OP_W)
  ) u_opcode_class (
    .opcode   (in_ir[31 -: OPC_W]),
    .op_class (op_class),
    .alu_op   (cls_alu_op)
  );

  assign is_alu    = (op_class == ClsRalu) || (op_class == ClsIalu);
  assign out_state = state_q;

  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q   <= T0;
      t1_wait_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      t1_wait_q <= (state_q == T1) && !in_mem_ack;
    end
  end

  always_comb begin
    state_d          = state_q;
    out_pcout        = 1'b0;
    out_pcin         = 1'b0;
    out_incpc        = 1'b0;
    out_marin        = 1'b0;
    out_mdrin        = 1'b0;
    out_mdrout       = 1'b0;
    out_irin         = 1'b0;
    out_mem_read     = 1'b0;
    out_mem_write    = 1'b0;
    out_mdr_from_mem = 1'b0;
    out_gra          = 1'b0;
    out_grb          = 1'b0;
    out_grc          = 1'b0;
    out_rout         = 1'b0;
    out_rin          = 1'b0;
    out_baout        = 1'b0;
    out_yin          = 1'b0;
    out_zin          = 1'b0;
    out_zlowout      = 1'b0;
    out_cout         = 1'b0;
    out_alu_op       = '0;
    out_illegal      = 1'b0;

    case (state_q)
      T0: begin
        // Reset gating keeps T0 strobes quiet while reset is held with run high
        if (in_run && in_reset_n) begin
          out_pcout = 1'b1;
          out_marin = 1'b1;
          out_incpc = 1'b1;
          out_zin   = 1'b1;
          state_d   = T1;
        end
      end
      T1: begin
        out_zlowout      = 1'b1;
        out_pcin         = !t1_wait_q;  // PC loads once even if memory stalls
        out_mem_read     = 1'b1;
        out_mdrin        = 1'b1;
        out_mdr_from_mem = 1'b1;
        if (in_mem_ack) state_d = T2;
      end
      T2: begin
        out_mdrout = 1'b1;
        out_irin   = 1'b1;
        state_d    = T3;
      end
      T3: begin
        if (op_class == ClsIllegal) begin
          out_illegal = 1'b1;
          state_d     = T0;
        end else begin
          out_grb   = 1'b1;
          out_yin   = 1'b1;
          out_rout  = is_alu;
          out_baout = !is_alu;  // ld/ldi/st address base; R0 reads as zero
          state_d   = T4;
        end
      end
      T4: begin
        out_zin    = 1'b1;
        out_alu_op = cls_alu_op;
        if (op_class == ClsRalu) begin
          out_grc  = 1'b1;
          out_rout = 1'b1;
        end else begin
          out_cout = 1'b1;
        end
        state_d = T5;
      end
      T5: begin
        out_zlowout = 1'b1;
        if (op_class == ClsLd || op_class == ClsSt) begin
          out_marin = 1'b1;
          state_d   = T6;
        end else begin
          out_gra = 1'b1;
          out_rin = 1'b1;
          state_d = T0;
        end
      end
      T6: begin
        out_mdrin = 1'b1;
        if (op_class == ClsLd) begin
          out_mem_read     = 1'b1;
          out_mdr_from_mem = 1'b1;
          if (in_mem_ack) state_d = T7;
        end else begin
          out_gra  = 1'b1;
          out_rout = 1'b1;
          state_d  = T7;
        end
      end
      T7: begin
        if (op_class == ClsSt) begin
          out_mem_write = 1'b1;
          if (in_mem_ack) state_d = T0;
        end else begin
          out_mdrout = 1'b1;
          out_gra    = 1'b1;
          out_rin    = 1'b1;
          state_d    = T0;
        end
      end
      default: state_d = T0;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: a table of directed instructions
// with expected cycle/strobe totals, hand-written reset and run-drop sequences,
// and random instructions, all compared cycle by cycle against a trace model.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        ack = 1'b0;
  logic [31:0] ir = '0;

  logic pcout, pcin, incpc, marin, mdrin, mdrout, irin, mem_read, mem_write;
  logic mdr_from_mem, gra, grb, grc, rout, rin, baout, yin, zin, zlowout, cout, illegal;
  logic [3:0] alu_op;
  logic [2:0] state;

  control_sequencer #(
    .OPC_W    (5),
    .ALU_OP_W (4)
  ) dut (
    .in_clk           (clk),
    .in_reset_n       (rst_n),
    .in_run           (run),
    .in_ir            (ir),
    .in_mem_ack       (ack),
    .out_pcout        (pcout),
    .out_pcin         (pcin),
    .out_incpc        (incpc),
    .out_marin        (marin),
    .out_mdrin        (mdrin),
    .out_mdrout       (mdrout),
    .out_irin         (irin),
    .out_mem_read     (mem_read),
    .out_mem_write    (mem_write),
    .out_mdr_from_mem (mdr_from_mem),
    .out_gra          (gra),
    .out_grb          (grb),
    .out_grc          (grc),
    .out_rout         (rout),
    .out_rin          (rin),
    .out_baout        (baout),
    .out_yin          (yin),
    .out_zin          (zin),
    .out_zlowout      (zlowout),
    .out_cout         (cout),
    .out_alu_op       (alu_op),
    .out_illegal      (illegal),
    .out_state        (state)
  );

  always #5 clk = ~clk;

  localparam logic [20:0] M_PCOUT = 21'd1 << 20;
  localparam logic [20:0] M_PCIN  = 21'd1 << 19;
  localparam logic [20:0] M_INCPC = 21'd1 << 18;
  localparam logic [20:0] M_MARIN = 21'd1 << 17;
  localparam logic [20:0] M_MDRIN = 21'd1 << 16;
  localparam logic [20:0] M_MDROUT= 21'd1 << 15;
  localparam logic [20:0] M_IRIN  = 21'd1 << 14;
  localparam logic [20:0] M_MRD   = 21'd1 << 13;
  localparam logic [20:0] M_MWR   = 21'd1 << 12;
  localparam logic [20:0] M_MFM   = 21'd1 << 11;
  localparam logic [20:0] M_GRA   = 21'd1 << 10;
  localparam logic [20:0] M_GRB   = 21'd1 << 9;
  localparam logic [20:0] M_GRC   = 21'd1 << 8;
  localparam logic [20:0] M_ROUT  = 21'd1 << 7;
  localparam logic [20:0] M_RIN   = 21'd1 << 6;
  localparam logic [20:0] M_BAOUT = 21'd1 << 5;
  localparam logic [20:0] M_YIN   = 21'd1 << 4;
  localparam logic [20:0] M_ZIN   = 21'd1 << 3;
  localparam logic [20:0] M_ZLO   = 21'd1 << 2;
  localparam logic [20:0] M_COUT  = 21'd1 << 1;
  localparam logic [20:0] M_ILL   = 21'd1;

  logic [20:0] sig;
  assign sig = {pcout, pcin, incpc, marin, mdrin, mdrout, irin, mem_read, mem_write,
                mdr_from_mem, gra, grb, grc, rout, rin, baout, yin, zin, zlowout, cout,
                illegal};

  // One expected clock cycle: strobes, ALU op, T-state, whether it waits on
  // ack, and whether ack is to be given in it.
  typedef struct packed {
    logic [20:0] sig;
    logic [3:0]  alu;
    logic [2:0]  st;
    logic        wt;
    logic        ak;
  } rec_t;

  typedef struct {
    logic [31:0] ir;
    int          d1;
    int          d2;
    int          cyc;
    int          rin;
    int          incpc;
    int          ill;
    int          drop;
  } vec_t;

  rec_t trace[$];
  vec_t tbl[12];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // 0 R-ALU, 1 I-ALU, 2 ld, 3 ldi, 4 st, 5 illegal
  function automatic int cls_of(input logic [4:0] o);
    if (o >= 5'd3 && o <= 5'd8) return 0;
    if (o >= 5'd9 && o <= 5'd11) return 1;
    if (o == 5'd0) return 2;
    if (o == 5'd1) return 3;
    if (o == 5'd2) return 4;
    return 5;
  endfunction

  function automatic logic [3:0] alu_of(input logic [4:0] o);
    int c;
    c = cls_of(o);
    if (c == 0) return 4'(o - 5'd3);
    if (c == 1) return (o == 5'd9) ? 4'd0 : (o == 5'd10) ? 4'd2 : 4'd3;
    return 4'd0;
  endfunction

  function automatic void push(input logic [20:0] s, input logic [3:0] a, input logic [2:0] st,
                               input logic wt, input logic ak);
    rec_t r;
    r.sig = s; r.alu = a; r.st = st; r.wt = wt; r.ak = ak;
    trace.push_back(r);
  endfunction

  function automatic void build(input logic [31:0] instr, input int d1, input int d2);
    int c;
    logic [4:0] o;
    o = instr[31:27];
    c = cls_of(o);
    trace.delete();
    push(M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 4'd0, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i <= d1; i++)
      push(M_ZLO | M_MRD | M_MDRIN | M_MFM | ((i == 0) ? M_PCIN : 21'd0), 4'd0, 3'd1, 1'b1,
           i == d1);
    push(M_MDROUT | M_IRIN, 4'd0, 3'd2, 1'b0, 1'b0);
    if (c == 5) begin
      push(M_ILL, 4'd0, 3'd3, 1'b0, 1'b0);
      return;
    end
    push(M_GRB | M_YIN | ((c <= 1) ? M_ROUT : M_BAOUT), 4'd0, 3'd3, 1'b0, 1'b0);
    if (c == 0) push(M_GRC | M_ROUT | M_ZIN, alu_of(o), 3'd4, 1'b0, 1'b0);
    else        push(M_COUT | M_ZIN, alu_of(o), 3'd4, 1'b0, 1'b0);
    if (c == 2 || c == 4) begin
      push(M_ZLO | M_MARIN, 4'd0, 3'd5, 1'b0, 1'b0);
      if (c == 2) begin
        for (int i = 0; i <= d2; i++)
          push(M_MRD | M_MDRIN | M_MFM, 4'd0, 3'd6, 1'b1, i == d2);
        push(M_MDROUT | M_GRA | M_RIN, 4'd0, 3'd7, 1'b0, 1'b0);
      end else begin
        push(M_GRA | M_ROUT | M_MDRIN, 4'd0, 3'd6, 1'b0, 1'b0);
        for (int i = 0; i <= d2; i++)
          push(M_MWR, 4'd0, 3'd7, 1'b1, i == d2);
      end
    end else begin
      push(M_ZLO | M_GRA | M_RIN, 4'd0, 3'd5, 1'b0, 1'b0);
    end
  endfunction

  // Entered #1 after a posedge with the DUT in T0; leaves at the same phase.
  task automatic run_instr(input logic [31:0] instr, input int d1, input int d2, input int drop,
                           output int cyc, output int n_rin, output int n_inc, output int n_ill);
    rec_t r;
    cyc = 1; n_rin = 0; n_inc = 0; n_ill = 0;
    ir  = instr;
    run = 1'b1;
    build(instr, d1, d2);
    for (int k = 0; k < trace.size(); k++) begin
      r = trace[k];
      if (drop >= 0 && k >= drop) run = 1'b0;
      ack = r.wt ? r.ak : 1'($urandom_range(0, 1));
      @(negedge clk);
      check($sformatf("trace ir=%h step%0d T%0d", instr, k, r.st),
            32'({sig, alu_op, state}), 32'({r.sig, r.alu, r.st}));
      if (k > 0 && state != 3'd0) cyc++;
      if (rin) n_rin++;
      if (incpc) n_inc++;
      if (illegal) n_ill++;
      @(posedge clk);
      #1;
    end
    ack = 1'b0;
    check($sformatf("back_to_T0 ir=%h", instr), 32'(state), 32'd0);
  endtask

  initial begin
    int cyc, n_rin, n_inc, n_ill, d1, d2;
    logic [31:0] instr;

    tbl[0]  = '{32'h18918000, 0, 0,  6, 1, 1, 0, -1};  // add r1,r2,r3
    tbl[1]  = '{32'h02000010, 3, 3, 14, 1, 1, 0, -1};  // ld r4,0x10(r0)
    tbl[2]  = '{32'h12B00020, 0, 2, 10, 0, 1, 0, -1};  // st r5,0x20(r6)
    tbl[3]  = '{32'hF8000000, 0, 0,  4, 0, 1, 1, -1};  // opcode 11111
    tbl[4]  = '{32'h08800005, 1, 0,  7, 1, 1, 0, -1};  // ldi
    tbl[5]  = '{32'h20918000, 2, 0,  8, 1, 1, 0, -1};  // sub
    tbl[6]  = '{32'h40918000, 0, 0,  6, 1, 1, 0, -1};  // shl
    tbl[7]  = '{32'h58800003, 1, 0,  7, 1, 1, 0, -1};  // ori
    tbl[8]  = '{32'h60000000, 2, 0,  6, 0, 1, 1, -1};  // opcode 01100
    tbl[9]  = '{32'h28918000, 0, 0,  6, 1, 1, 0, -1};  // and
    tbl[10] = '{32'h38918000, 1, 0,  7, 1, 1, 0, -1};  // shr
    tbl[11] = '{32'h48800001, 0, 0,  6, 1, 1, 0,  4};  // addi, run drops in T4

    // Reset held with run high: everything quiet
    run = 1'b1;
    @(negedge clk);
    check("reset_sig", 32'(sig), 32'd0);
    check("reset_alu_state", 32'({alu_op, state}), 32'd0);
    rst_n = 1'b1;
    #1;
    check("T0_after_release", 32'(sig), 32'(M_PCOUT | M_MARIN | M_INCPC | M_ZIN));
    @(posedge clk);
    #1;
    check("T1_mem_read", 32'({mem_read, state}), 32'({1'b1, 3'd1}));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_sig", 32'(sig), 32'd0);
    check("async_reset_state", 32'(state), 32'd0);
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("parked_T0", 32'({sig, state}), 32'd0);

    for (int i = 0; i < 12; i++) begin
      run_instr(tbl[i].ir, tbl[i].d1, tbl[i].d2, tbl[i].drop, cyc, n_rin, n_inc, n_ill);
      check($sformatf("cycles[%0d]", i), 32'(cyc), 32'(tbl[i].cyc));
      check($sformatf("rin_count[%0d]", i), 32'(n_rin), 32'(tbl[i].rin));
      check($sformatf("incpc_count[%0d]", i), 32'(n_inc), 32'(tbl[i].incpc));
      check($sformatf("illegal_count[%0d]", i), 32'(n_ill), 32'(tbl[i].ill));
      if (tbl[i].drop >= 0) begin
        for (int j = 0; j < 3; j++) begin
          ack = 1'($urandom_range(0, 1));
          @(negedge clk);
          check($sformatf("run_low_park%0d", j), 32'({sig, alu_op, state}), 32'd0);
          @(posedge clk);
          #1;
        end
        ack = 1'b0;
      end
    end

    for (int i = 0; i < 60; i++) begin
      instr = {5'($urandom_range(0, 31)), 27'($urandom)};
      d1 = $urandom_range(0, 3);
      d2 = $urandom_range(0, 3);
      run_instr(instr, d1, d2, -1, cyc, n_rin, n_inc, n_ill);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
